// File: rtl/imm_decode_stage.sv
// Registered RISC-V immediate decoder with valid/ready flow control and a 1-entry skid buffer.
// Classifies the format from the opcode, extends the immediate to XLEN and carries a sideband tag.
module imm_decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_OPIMM    = 7'b0010011;
  localparam logic [6:0] OP_OPIMM32  = 7'b0011011;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_MISCMEM  = 7'b0001111;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ZIMM  = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } res_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  fmt_e            fmt_c;
  logic            illegal_c;
  logic [XLEN-1:0] imm_c;
  res_t            dec_c;

  res_t out_q, out_d;
  res_t skid_q, skid_d;
  logic out_valid_q, out_valid_d;
  logic skid_valid_q, skid_valid_d;
  logic take_c;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];

  // Format classification from the opcode (and funct3 where it disambiguates)
  always_comb begin
    fmt_c     = FMT_NONE;
    illegal_c = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC:             fmt_c = FMT_U;
      OP_JAL:                       fmt_c = FMT_J;
      OP_JALR, OP_LOAD, OP_MISCMEM: fmt_c = FMT_I;
      OP_STORE:                     fmt_c = FMT_S;
      OP_BRANCH:                    fmt_c = FMT_B;
      OP_OP:                        fmt_c = FMT_NONE;
      OP_OPIMM:                     fmt_c = (funct3[1:0] == 2'b01) ? FMT_SHAMT : FMT_I;
      OP_OPIMM32: begin
        if (XLEN == 64) fmt_c = (funct3[1:0] == 2'b01) ? FMT_SHAMT : FMT_I;
        else            illegal_c = 1'b1;
      end
      OP_SYSTEM:                    fmt_c = funct3[2] ? FMT_ZIMM : FMT_I;
      default:                      illegal_c = 1'b1;
    endcase
  end

  // Immediate extraction; signed formats sign-extend from inst[31]
  always_comb begin
    imm_c = '0;
    case (fmt_c)
      FMT_I: imm_c = XLEN'($signed(in_inst[31:20]));
      FMT_S: imm_c = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
      FMT_B: imm_c = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                    in_inst[11:8], 1'b0}));
      FMT_U: imm_c = XLEN'($signed({in_inst[31:12], 12'b0}));
      FMT_J: imm_c = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                    in_inst[30:21], 1'b0}));
      FMT_SHAMT: begin
        if (XLEN == 64 && opcode == OP_OPIMM) imm_c = XLEN'(in_inst[25:20]);
        else                                  imm_c = XLEN'(in_inst[24:20]);
      end
      FMT_ZIMM: imm_c = XLEN'(in_inst[19:15]);
      default:  imm_c = '0;
    endcase
  end

  assign dec_c = '{imm: imm_c, fmt: fmt_c, illegal: illegal_c, tag: in_tag};

  // in_ready depends only on the skid flag, never on out_ready
  assign in_ready = ~skid_valid_q;
  assign take_c   = in_valid & ~skid_valid_q & ~flush;

  // Output/skid next state: skid drains first so order is preserved
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (take_c) begin
        out_d       = dec_c;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (take_c) begin
      skid_d       = dec_c;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;
  assign out_tag     = out_q.tag;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed self-checking bench for imm_decode_stage; drives an XLEN=32 and an XLEN=64
// instance from the same input stream and compares against hand-computed values.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        r32_in_ready, r32_out_valid, r32_illegal;
  logic [31:0] r32_imm, r32_tag;
  logic [2:0]  r32_fmt;
  logic        r64_in_ready, r64_out_valid, r64_illegal;
  logic [63:0] r64_imm;
  logic [31:0] r64_tag;
  logic [2:0]  r64_fmt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .TAG_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r32_in_ready), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(r32_out_valid), .out_ready(out_ready), .out_imm(r32_imm),
    .out_fmt(r32_fmt), .out_illegal(r32_illegal), .out_tag(r32_tag)
  );

  imm_decode_stage #(.XLEN(64), .TAG_W(32)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r64_in_ready), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(r64_out_valid), .out_ready(out_ready), .out_imm(r64_imm),
    .out_fmt(r64_fmt), .out_illegal(r64_illegal), .out_tag(r64_tag)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One word through both instances with out_ready=1; result must appear after one edge
  task automatic vec(input string name, input logic [31:0] inst, input logic [31:0] tag,
                     input logic [31:0] imm32, input logic [2:0] fmt32, input logic ill32,
                     input logic [63:0] imm64, input logic [2:0] fmt64, input logic ill64);
    in_valid = 1'b1;
    in_inst  = inst;
    in_tag   = tag;
    tick();
    in_valid = 1'b0;
    check($sformatf("%s v32", name), 64'(r32_out_valid), 64'd1);
    check($sformatf("%s imm32", name), 64'(r32_imm), 64'(imm32));
    check($sformatf("%s fmt32", name), 64'(r32_fmt), 64'(fmt32));
    check($sformatf("%s ill32", name), 64'(r32_illegal), 64'(ill32));
    check($sformatf("%s tag32", name), 64'(r32_tag), 64'(tag));
    check($sformatf("%s imm64", name), r64_imm, imm64);
    check($sformatf("%s fmt64", name), 64'(r64_fmt), 64'(fmt64));
    check($sformatf("%s ill64", name), 64'(r64_illegal), 64'(ill64));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_tag = '0; out_ready = 1'b1;
    tick();
    check("rst out_valid", 64'(r32_out_valid), 64'd0);
    check("rst in_ready", 64'(r32_in_ready), 64'd1);
    check("rst imm", 64'(r32_imm), 64'd0);
    check("rst fmt", 64'(r32_fmt), 64'd0);
    check("rst illegal", 64'(r32_illegal), 64'd0);
    check("rst tag", 64'(r32_tag), 64'd0);
    check("rst out_valid64", 64'(r64_out_valid), 64'd0);
    rst = 1'b0;
    tick();

    //   name      inst          tag    imm32         f  il  imm64                   f  il
    vec("addi",  32'hFFF00093, 32'h1, 32'hFFFFFFFF, 1, 0, 64'hFFFFFFFFFFFFFFFF, 1, 0);
    vec("beq",   32'hFE000EE3, 32'h2, 32'hFFFFFFFC, 3, 0, 64'hFFFFFFFFFFFFFFFC, 3, 0);
    vec("lui",   32'h123452B7, 32'h3, 32'h12345000, 4, 0, 64'h0000000012345000, 4, 0);
    vec("luineg",32'h800002B7, 32'h4, 32'h80000000, 4, 0, 64'hFFFFFFFF80000000, 4, 0);
    vec("srai",  32'h41F0D093, 32'h5, 32'h0000001F, 6, 0, 64'h000000000000001F, 6, 0);
    vec("ill7f", 32'h0000007F, 32'h6, 32'h00000000, 0, 1, 64'h0, 0, 1);
    vec("sw",    32'hFE20AC23, 32'h7, 32'hFFFFFFF8, 2, 0, 64'hFFFFFFFFFFFFFFF8, 2, 0);
    vec("add",   32'h002081B3, 32'h8, 32'h00000000, 0, 0, 64'h0, 0, 0);
    vec("csrwi", 32'h300FD0F3, 32'h9, 32'h0000001F, 7, 0, 64'h000000000000001F, 7, 0);
    vec("csrw",  32'h80009073, 32'hA, 32'hFFFFF800, 1, 0, 64'hFFFFFFFFFFFFF800, 1, 0);
    vec("jal",   32'h801FF0EF, 32'hB, 32'hFFFFF800, 5, 0, 64'hFFFFFFFFFFFFF800, 5, 0);
    vec("slli63",32'h03F09093, 32'hC, 32'h0000001F, 6, 0, 64'h000000000000003F, 6, 0);
    vec("slliw", 32'h01F0909B, 32'hD, 32'h00000000, 0, 1, 64'h000000000000001F, 6, 0);
    vec("addiw", 32'hFFF0809B, 32'hE, 32'h00000000, 0, 1, 64'hFFFFFFFFFFFFFFFF, 1, 0);
    tick();
    check("drain idle", 64'(r32_out_valid), 64'd0);

    // Backpressure: A to output, B to skid, C stalls
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_tag = 32'hA;
    tick();
    check("bp A valid", 64'(r32_out_valid), 64'd1);
    check("bp A in_ready", 64'(r32_in_ready), 64'd1);
    in_inst = 32'h123452B7; in_tag = 32'hB;
    tick();
    check("bp B in_ready", 64'(r32_in_ready), 64'd0);
    check("bp A held tag", 64'(r32_tag), 64'hA);
    in_inst = 32'hFE000EE3; in_tag = 32'hC;
    tick();
    check("bp C stall in_ready", 64'(r32_in_ready), 64'd0);
    check("bp A stable imm", 64'(r32_imm), 64'hFFFFFFFF);
    check("bp A stable tag", 64'(r32_tag), 64'hA);
    out_ready = 1'b1;
    tick();
    check("bp B valid", 64'(r32_out_valid), 64'd1);
    check("bp B tag", 64'(r32_tag), 64'hB);
    check("bp B imm", 64'(r32_imm), 64'h12345000);
    check("bp B in_ready", 64'(r32_in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp C valid", 64'(r32_out_valid), 64'd1);
    check("bp C tag", 64'(r32_tag), 64'hC);
    check("bp C imm", 64'(r32_imm), 64'hFFFFFFFC);
    tick();
    check("bp empty", 64'(r32_out_valid), 64'd0);

    // Flush with both entries full while D is presented
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_tag = 32'h11;
    tick();
    in_tag = 32'h12;
    tick();
    check("fl full in_ready", 64'(r32_in_ready), 64'd0);
    in_inst = 32'h123452B7; in_tag = 32'hDD; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl out_valid", 64'(r32_out_valid), 64'd0);
    check("fl in_ready", 64'(r32_in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl no D", 64'(r32_out_valid), 64'd0);
    end

    // Flush overrides acceptance with the stage empty
    in_valid = 1'b1; in_inst = 32'h123452B7; in_tag = 32'hEE; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl drop E", 64'(r32_out_valid), 64'd0);
    check("fl drop E 64", 64'(r64_out_valid), 64'd0);

    // Async reset mid-transfer
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_tag = 32'h21;
    tick();
    in_tag = 32'h22;
    tick();
    in_valid = 1'b0;
    check("pre-rst valid", 64'(r32_out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst async valid", 64'(r32_out_valid), 64'd0);
    check("rst async in_ready", 64'(r32_in_ready), 64'd1);
    check("rst async tag", 64'(r32_tag), 64'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    check("post-rst idle", 64'(r32_out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
